// File: rtl/ts_seq_pkg.sv
// Shared constants for the ring-oscillator measurement sequencer: FSM states,
// mode/source encodings and a small sizing helper.
package ts_seq_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE  = 3'd1;
  localparam logic [2:0] COUNT   = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] HOLD    = 3'd5;

  localparam logic [1:0] MODE_INV  = 2'b00;
  localparam logic [1:0] MODE_NAND = 2'b01;
  localparam logic [1:0] MODE_ALT  = 2'b10;

  localparam logic SRC_INV  = 1'b0;
  localparam logic SRC_NAND = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ts_meas_sequencer_timer.sv
// Loadable down-counter shared by the timed states of the measurement sequencer.
// Holds at zero instead of wrapping.
module ts_seq_timer #(
  parameter int W = 10
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk_in) begin
    if (!rst_n)
      value <= '0;
    else if (load)
      value <= load_val;
    else if (value != '0)
      value <= value - 1'b1;
  end

  assign zero = (value == '0);

endmodule

// File: rtl/ts_meas_sequencer.sv
// Schedules one ring-oscillator temperature measurement at a time and hands the count over valid/ready.
// Define TS_SEQ_PERIODIC_EN to add a free-running auto-trigger every PERIOD_CYC cycles.
module ts_meas_sequencer
  import ts_seq_pkg::*;
#(
  parameter int CNT_W      = 10,
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW_CYC = 1000,
  parameter int DRAIN_CYC  = 3,
  parameter int PERIOD_CYC = 10000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic             osc_en_inv,
  output logic             osc_en_nand,
  output logic             osc_sel,
  output logic             cnt_clr,
  output logic             cnt_en,
  input  logic [CNT_W-1:0] count_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_data,
  output logic             res_src,
  output logic             res_ovf,
  output logic             busy
);

  localparam int MAX_CYC = max3(SETTLE_CYC, WINDOW_CYC, DRAIN_CYC);
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Each timed state is loaded with N-1 so it lasts exactly N cycles.
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW_CYC - 1);
  localparam logic [TMR_W-1:0] DRAIN_LD  = TMR_W'(DRAIN_CYC - 1);

  if (SETTLE_CYC < 1 || WINDOW_CYC < 1 || DRAIN_CYC < 1 ||
      PERIOD_CYC <= SETTLE_CYC + WINDOW_CYC + DRAIN_CYC + 2) begin : g_param_check
    $error("ts_meas_sequencer: illegal cycle-count parameters");
  end

  logic [2:0]       state_q, state_d;
  logic [1:0]       mode_q;
  logic             src_q;
  logic             alt_ptr;
  logic             new_src;
  logic             trig;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_zero;
  logic             osc_on;

`ifdef TS_SEQ_PERIODIC_EN
  localparam int PER_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);

  logic [PER_W-1:0] period_cnt;

  // Free-running from reset; a tick arriving outside IDLE is simply lost.
  always_ff @(posedge clk_in) begin
    if (!rst_n)
      period_cnt <= '0;
    else if (period_cnt == PER_LAST)
      period_cnt <= '0;
    else
      period_cnt <= period_cnt + 1'b1;
  end

  assign trig = start | (period_cnt == PER_LAST);
`else
  assign trig = start;
`endif

  assign new_src = (mode == MODE_NAND) ? SRC_NAND :
                   (mode == MODE_ALT)  ? alt_ptr  : SRC_INV;

  ts_seq_timer #(.W(TMR_W)) u_timer (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d  = COUNT;
          tmr_load = 1'b1;
          tmr_val  = WINDOW_LD;
        end
      end
      COUNT: begin
        if (tmr_zero) begin
          state_d  = DRAIN;
          tmr_load = 1'b1;
          tmr_val  = DRAIN_LD;
        end
      end
      DRAIN:   if (tmr_zero) state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_INV;
      src_q    <= SRC_INV;
      alt_ptr  <= SRC_INV;
      res_data <= '0;
      res_src  <= 1'b0;
      res_ovf  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && trig) begin
        mode_q <= mode;
        src_q  <= new_src;
      end
      if (state_q == CAPTURE) begin
        res_data <= count_in;
        res_src  <= src_q;
        res_ovf  <= &count_in;
        if (mode_q == MODE_ALT)
          alt_ptr <= ~alt_ptr;
      end
    end
  end

  assign osc_on      = (state_q == SETTLE) || (state_q == COUNT) || (state_q == DRAIN);
  assign osc_en_inv  = osc_on && (src_q == SRC_INV);
  assign osc_en_nand = osc_on && (src_q == SRC_NAND);
  assign osc_sel     = osc_on && src_q;
  // The timer still holds its load value only on the first settle cycle.
  assign cnt_clr     = (state_q == SETTLE) && (tmr_value == SETTLE_LD);
  assign cnt_en      = (state_q == COUNT);
  assign res_valid   = (state_q == HOLD);
  assign busy        = (state_q != IDLE);

endmodule
